hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_NUM_BITS, default 4, giving the register index width (16 architectural registers).
REQ-002 The block SHALL have parameter MAX_INFLIGHT, default 3, giving the maximum outstanding writes per register and per flag set (EXE, MEM, WB).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 src1  in  REG_NUM_BITS  Rn index of the decoding instruction.
REQ-006 src1_valid  in  1  the decoding instruction reads Rn.
REQ-007 src2  in  REG_NUM_BITS  Rm or Rd index, after the store-select mux.
REQ-008 two_src  in  1  the decoding instruction reads src2.
REQ-009 uses_flags  in  1  the decoding instruction has a condition other than AL.
REQ-010 issue_valid  in  1  a decoded instruction is present in ID.
REQ-011 issue_wb_en, issue_s  in  1 each  the decoding instruction writes a register or the status flags.
REQ-012 issue_dest  in  REG_NUM_BITS  destination register of the decoding instruction.
REQ-013 write_back_en  in  1, dest_wb  in  REG_NUM_BITS  register write-back retiring a pending write.
REQ-014 flags_wr  in  1  the status register was updated in EXE this cycle.
REQ-015 drain_req  in  1  level request to empty the pipeline.
REQ-016 hazard  out  1  stall ID and freeze IF.
REQ-017 busy  out  1  at least one write is pending.
REQ-018 drain_done  out  1  one-cycle pulse when a drain completes.
REQ-019 err  out  1  sticky underflow error.

Function
REQ-020 Each register SHALL have a pending counter of width clog2(MAX_INFLIGHT+1); the flag set SHALL have one counter of the same width.
REQ-021 hazard SHALL be combinational and SHALL be asserted when issue_valid is high and any of these conditions holds:
- src1_valid and cnt[src1] != 0
- two_src and cnt[src2] != 0
- uses_flags and flag_cnt != 0
- issue_wb_en and cnt[issue_dest] == MAX_INFLIGHT
- issue_s and flag_cnt == MAX_INFLIGHT
- state is not RUN
REQ-022 The block SHALL issue an instruction when issue_valid is high and hazard is low; on issue, issue_wb_en SHALL increment cnt[issue_dest] and issue_s SHALL increment flag_cnt.
REQ-023 write_back_en SHALL decrement cnt[dest_wb], and flags_wr SHALL decrement flag_cnt, at the next edge.
REQ-024 On a simultaneous issue and retire to the same counter, the counter SHALL be left unchanged.
REQ-025 A retire to a counter at 0 SHALL leave the counter at 0 and set err, which stays set until rst.
REQ-026 Write-back in a cycle SHALL NOT clear a same-cycle hazard; there is no bypass, so a stall always lasts at least one cycle.
REQ-027 busy SHALL equal the OR of all counters being non-zero, registered state only.
REQ-028 FSM states SHALL be RUN, DRAIN and DONE:
- RUN to DRAIN when drain_req is high.
- DRAIN to DONE when all counters are 0, including counters that reach 0 that same edge.
- DONE asserts drain_done for one cycle, then goes to RUN if drain_req is low, else stays in DRAIN with no further pulse until drain_req drops.
- While in DRAIN, if drain_req falls before the counters are empty, the FSM SHALL return to RUN.
REQ-029 Retires SHALL continue to be processed in every state.

Reset
REQ-030 On rst, at the edge, all counters SHALL clear to 0, state SHALL go to RUN, err SHALL clear, and drain_done SHALL be 0; rst overrides all same-cycle issue and retire events.
REQ-031 After reset, busy SHALL be 0 and hazard SHALL be 0 unless issue_valid is high with blocking inputs.

Structure
REQ-032 REG_NUM_BITS, MAX_INFLIGHT and the FSM state encoding SHALL live in the shared pipeline package.
REQ-033 One sub-module, sb_counter (saturating up/down pending counter with an underflow flag), SHALL be instantiated 17 times: 16 registers plus flags.

Verification
REQ-034 Issue ADD wb R3, then next cycle decode SUB reading R3 -> hazard=1 until write_back_en with dest_wb=3, hazard=0 the following cycle.
REQ-035 Issue 3 writes to R5 back-to-back, then a 4th write to R5 -> 4th stalls (cnt=3), released one cycle after the first R5 retire.
REQ-036 Issue CMP (issue_s=1), then decode a conditional MOVEQ -> hazard until flags_wr, then issues.
REQ-037 Same-cycle issue to R7 and retire to R7 with cnt[7]=1 -> cnt[7] stays 1 and busy stays 1.
REQ-038 Retire R9 with cnt[9]=0 -> err=1, cnt[9]=0, err persists until rst.
REQ-039 drain_req with 2 pending writes -> hazard=1, drain_done pulses exactly once in the cycle after the last retire, and rst during DRAIN returns to RUN with no pulse.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the register/flag hazard scoreboard:
// default sizing and the drain FSM state encoding.
package hazard_scoreboard_pkg;

    localparam int REG_NUM_BITS = 4;
    localparam int MAX_INFLIGHT = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Saturating up/down pending-write counter; a retire at zero holds the count
// and raises a one-cycle underflow indication.
module sb_counter #(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);

    // NOTE: every output of this always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        underflow  = 1'b0;
        if (inc && !dec) begin
            if (count != CNT_FULL) count_next = count + 1'b1;
        end else if (dec && !inc) begin
            if (count == '0) underflow  = 1'b1;
            else             count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= count_next;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register and flag pending-write counters,
// stall generation, sticky underflow error and a pipeline drain handshake.
module hazard_scoreboard #(
    parameter int REG_NUM_BITS = hazard_scoreboard_pkg::REG_NUM_BITS,
    parameter int MAX_INFLIGHT = hazard_scoreboard_pkg::MAX_INFLIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_NUM_BITS-1:0] src1,
    input  logic                    src1_valid,
    input  logic [REG_NUM_BITS-1:0] src2,
    input  logic                    two_src,
    input  logic                    uses_flags,
    input  logic                    issue_valid,
    input  logic                    issue_wb_en,
    input  logic                    issue_s,
    input  logic [REG_NUM_BITS-1:0] issue_dest,
    input  logic                    write_back_en,
    input  logic [REG_NUM_BITS-1:0] dest_wb,
    input  logic                    flags_wr,
    input  logic                    drain_req,
    output logic                    hazard,
    output logic                    busy,
    output logic                    drain_done,
    output logic                    err
);

    import hazard_scoreboard_pkg::*;

    localparam int NUM_REGS = 1 << REG_NUM_BITS;
    localparam int CNT_W    = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0] reg_inc, reg_dec, reg_uf;
    logic [CNT_W-1:0]    reg_cnt      [NUM_REGS];
    logic [CNT_W-1:0]    reg_cnt_next [NUM_REGS];
    logic [CNT_W-1:0]    flag_cnt, flag_cnt_next;
    logic                flag_uf;
    logic                issue, all_empty_next;
    sb_state_e           state_q, state_d;
    logic                pulse_sent_q, pulse_sent_d;

    assign issue   = issue_valid && !hazard;
    assign reg_inc = (issue && issue_wb_en) ? (NUM_REGS'(1) << issue_dest) : '0;
    assign reg_dec = write_back_en ? (NUM_REGS'(1) << dest_wb) : '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        sb_counter #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .inc        (reg_inc[i]),
            .dec        (reg_dec[i]),
            .count      (reg_cnt[i]),
            .count_next (reg_cnt_next[i]),
            .underflow  (reg_uf[i])
        );
    end

    sb_counter #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_flag_cnt (
        .clk        (clk),
        .rst        (rst),
        .inc        (issue && issue_s),
        .dec        (flags_wr),
        .count      (flag_cnt),
        .count_next (flag_cnt_next),
        .underflow  (flag_uf)
    );

    // Hazards look only at registered counts: a same-cycle retire never releases a stall.
    always_comb begin
        hazard = (state_q != ST_RUN);
        if (src1_valid  && reg_cnt[src1] != '0)             hazard = 1'b1;
        if (two_src     && reg_cnt[src2] != '0)             hazard = 1'b1;
        if (uses_flags  && flag_cnt != '0)                  hazard = 1'b1;
        if (issue_wb_en && reg_cnt[issue_dest] == CNT_FULL) hazard = 1'b1;
        if (issue_s     && flag_cnt == CNT_FULL)            hazard = 1'b1;
        hazard = hazard && issue_valid;
    end

    always_comb begin
        busy           = (flag_cnt != '0);
        all_empty_next = (flag_cnt_next == '0);
        for (int i = 0; i < NUM_REGS; i++) begin
            busy           = busy || (reg_cnt[i] != '0);
            all_empty_next = all_empty_next && (reg_cnt_next[i] == '0);
        end
    end

    // pulse_sent keeps a held drain_req from producing a second drain_done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (all_empty_next && !pulse_sent_q) state_d = ST_DONE;
                else if (!drain_req)                 state_d = ST_RUN;
            end
            ST_DONE:  state_d = drain_req ? ST_DRAIN : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        pulse_sent_d = pulse_sent_q;
        if (state_d == ST_RUN)       pulse_sent_d = 1'b0;
        else if (state_d == ST_DONE) pulse_sent_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pulse_sent_q <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_sent_q <= pulse_sent_d;
            if (|reg_uf || flag_uf) err <= 1'b1;
        end
    end

    assign drain_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard, checked against a
// behavioural model of pending writes, the sticky error and the drain protocol.
module tb_hazard_scoreboard;

    localparam int NREG = 16;
    localparam int MAXI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, issue_dest, dest_wb;
    logic       src1_valid, two_src, uses_flags, issue_valid, issue_wb_en, issue_s;
    logic       write_back_en, flags_wr, drain_req;
    logic       hazard, busy, drain_done, err;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int m_cnt [NREG];
    int m_flag;
    bit m_err, m_draining, m_done, m_pulsed;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .src1(src1), .src1_valid(src1_valid), .src2(src2),
        .two_src(two_src), .uses_flags(uses_flags), .issue_valid(issue_valid),
        .issue_wb_en(issue_wb_en), .issue_s(issue_s), .issue_dest(issue_dest),
        .write_back_en(write_back_en), .dest_wb(dest_wb), .flags_wr(flags_wr),
        .drain_req(drain_req), .hazard(hazard), .busy(busy),
        .drain_done(drain_done), .err(err)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src1 = 0; src2 = 0; issue_dest = 0; dest_wb = 0;
        src1_valid = 0; two_src = 0; uses_flags = 0; issue_valid = 0;
        issue_wb_en = 0; issue_s = 0; write_back_en = 0; flags_wr = 0;
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_flag = 0; m_err = 0; m_draining = 0; m_done = 0; m_pulsed = 0;
    endtask

    function automatic bit model_hazard();
        bit h;
        h = m_draining;
        if (src1_valid && m_cnt[src1] > 0) h = 1;
        if (two_src && m_cnt[src2] > 0) h = 1;
        if (uses_flags && m_flag > 0) h = 1;
        if (issue_wb_en && m_cnt[issue_dest] == MAXI) h = 1;
        if (issue_s && m_flag == MAXI) h = 1;
        return issue_valid && h;
    endfunction

    function automatic bit model_busy();
        bit b;
        b = (m_flag > 0);
        foreach (m_cnt[i]) if (m_cnt[i] > 0) b = 1;
        return b;
    endfunction

    // Applies one pending-count event: +1 on issue, -1 on retire, both cancel.
    task automatic apply(inout int c, input bit up, input bit down);
        if (up && !down) c = (c < MAXI) ? c + 1 : c;
        else if (down && !up) begin
            if (c == 0) m_err = 1;
            else c = c - 1;
        end
    endtask

    task automatic model_step(input bit issued);
        bit empty;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NREG; i++)
            apply(m_cnt[i], issued && issue_wb_en && issue_dest == 4'(i),
                  write_back_en && dest_wb == 4'(i));
        apply(m_flag, issued && issue_s, flags_wr);
        empty = !model_busy();
        if (!m_draining) begin
            m_draining = drain_req;
            m_pulsed = 0;
        end else if (m_done) begin
            m_done = 0;
            m_draining = drain_req;
            if (!drain_req) m_pulsed = 0;
        end else if (empty && !m_pulsed) begin
            m_done = 1;
            m_pulsed = 1;
        end else if (!drain_req) begin
            m_draining = 0;
            m_pulsed = 0;
        end
    endtask

    // Check all outputs against the model, then advance one clock.
    task automatic cyc(input string tag);
        bit exp_h;
        #1;
        exp_h = model_hazard();
        check({tag, "_hazard"}, hazard, exp_h);
        check({tag, "_busy"}, busy, model_busy());
        check({tag, "_err"}, err, m_err);
        check({tag, "_drain_done"}, drain_done, m_done);
        @(posedge clk);
        model_step(issue_valid && !exp_h);
        @(negedge clk);
    endtask

    task automatic wr(input int r);
        idle(); issue_valid = 1; issue_wb_en = 1; issue_dest = 4'(r);
    endtask

    task automatic retire(input int r);
        idle(); write_back_en = 1; dest_wb = 4'(r);
    endtask

    initial begin
        rst = 1; drain_req = 0; idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        cyc("reset");
        rst = 0;
        #1 check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        issue_valid = 1; src1_valid = 1; src1 = 2;
        #1 check("reset_no_block", hazard, 0);
        cyc("reset_read");

        // RAW on R3 released only the cycle after its write-back
        wr(3); cyc("add_r3");
        wr(4); src1_valid = 1; src1 = 3;
        #1 check("sub_stall", hazard, 1);
        cyc("sub_stall1"); cyc("sub_stall2");
        write_back_en = 1; dest_wb = 3;
        #1 check("sub_stall_wb_same_cycle", hazard, 1);
        cyc("sub_wb");
        write_back_en = 0;
        #1 check("sub_release", hazard, 0);
        cyc("sub_issue");
        retire(4); cyc("ret_r4");
        idle();
        #1 check("idle_after_raw", busy, 0);

        // three in-flight writes to R5, the fourth stalls
        for (int k = 0; k < 3; k++) begin
            wr(5);
            #1 check("r5_fill", hazard, 0);
            cyc("r5_fill");
        end
        wr(5);
        #1 check("r5_full_stall", hazard, 1);
        cyc("r5_full");
        write_back_en = 1; dest_wb = 5;
        #1 check("r5_full_retire_cycle", hazard, 1);
        cyc("r5_retire");
        write_back_en = 0;
        #1 check("r5_release", hazard, 0);
        cyc("r5_fourth");
        for (int k = 0; k < 3; k++) begin retire(5); cyc("r5_drain"); end

        // flags dependency
        idle(); issue_valid = 1; issue_s = 1; cyc("cmp");
        idle(); issue_valid = 1; uses_flags = 1;
        #1 check("moveq_stall", hazard, 1);
        cyc("moveq_stall");
        flags_wr = 1;
        #1 check("moveq_flags_wr_cycle", hazard, 1);
        cyc("moveq_fw");
        flags_wr = 0;
        #1 check("moveq_release", hazard, 0);
        cyc("moveq_issue");

        // simultaneous issue and retire to R7
        wr(7); cyc("r7_first");
        wr(7); write_back_en = 1; dest_wb = 7; cyc("r7_both");
        idle();
        #1 check("r7_busy_kept", busy, 1);
        issue_valid = 1; two_src = 1; src2 = 7;
        #1 check("r7_still_pending", hazard, 1);
        cyc("r7_read");
        retire(7); cyc("r7_retire");
        idle();
        #1 check("r7_empty", busy, 0);

        // underflow on R9
        retire(9); cyc("r9_underflow");
        idle();
        #1 check("r9_err_set", err, 1);
        check("r9_not_busy", busy, 0);
        repeat (3) cyc("r9_hold");
        issue_valid = 1; src1_valid = 1; src1 = 9;
        #1 check("r9_cnt_zero", hazard, 0);
        check("r9_err_sticky", err, 1);
        cyc("r9_read");

        // drain with two pending writes
        wr(1); cyc("dr_w1");
        wr(2); cyc("dr_w2");
        idle(); drain_req = 1; cyc("dr_enter");
        issue_valid = 1;
        #1 check("dr_hazard", hazard, 1);
        check("dr_no_early_done", drain_done, 0);
        cyc("dr_wait");
        retire(1); cyc("dr_ret1");
        retire(2); cyc("dr_ret2");
        idle();
        #1 check("dr_done_pulse", drain_done, 1);
        cyc("dr_done");
        repeat (3) begin
            issue_valid = 1;
            #1 check("dr_no_second_pulse", drain_done, 0);
            cyc("dr_hold");
        end
        drain_req = 0; idle(); cyc("dr_drop");
        issue_valid = 1;
        #1 check("dr_back_to_run", hazard, 0);
        cyc("dr_run");

        // drain abandoned before empty
        wr(1); cyc("ab_w1");
        idle(); drain_req = 1; cyc("ab_enter"); cyc("ab_wait");
        drain_req = 0; cyc("ab_drop");
        issue_valid = 1;
        #1 check("ab_run_again", hazard, 0);
        cyc("ab_run");

        // reset in DRAIN: back to RUN, no pulse, error cleared
        idle(); drain_req = 1; cyc("rd_enter"); cyc("rd_wait");
        rst = 1; cyc("rd_reset");
        rst = 0; drain_req = 0;
        #1 check("rd_no_pulse", drain_done, 0);
        check("rd_err_clear", err, 0);
        check("rd_not_busy", busy, 0);
        cyc("rd_after");
        #1 check("rd_no_late_pulse", drain_done, 0);
        cyc("rd_after2");

        // randomized traffic over a small register window
        for (int n = 0; n < 500; n++) begin
            src1          = 4'($urandom_range(0, 3));
            src2          = 4'($urandom_range(0, 3));
            issue_dest    = 4'($urandom_range(0, 3));
            dest_wb       = 4'($urandom_range(0, 3));
            src1_valid    = 1'($urandom_range(0, 1));
            two_src       = 1'($urandom_range(0, 1));
            uses_flags    = ($urandom_range(0, 3) == 0);
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_wb_en   = ($urandom_range(0, 3) != 0);
            issue_s       = ($urandom_range(0, 3) == 0);
            write_back_en = ($urandom_range(0, 2) == 0);
            flags_wr      = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) drain_req = ~drain_req;
            rst           = ($urandom_range(0, 63) == 0);
            cyc("rnd");
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
